inst_fetch_responder: RTL and testbench

//  Instruction-side responder for the fetch unit's PC stream.
//  - Accepts a fetch request (byte address) and returns the 32-bit inst_code stored at that word.
//  - Backing store: an on-chip, word-organised program memory, preloaded through a separate write port.
//  - Sits between the address generator and the decode stage.
//  - Misaligned or out-of-range fetches return a fault flag plus a NOP.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/inst_mem_array.sv | 47 ++++
 rtl/inst_fetch_responder.sv | 92 +++++++++
 tb/tb_inst_fetch_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: word width, canonical NOP, base opcodes and the
// fetch responder's state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_CODE = 32'h00000013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Word-organised program RAM: one synchronous read port with enable, one write port.
// A same-address read and write in one cycle returns the old word.
module inst_mem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: range/alignment check, one-entry response FSM,
// and program-load port in front of the program RAM.
module inst_fetch_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] NOP_CODE    = riscv_pkg::NOP_CODE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] inst_address,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] inst_code,
    output logic        fetch_fault,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_err
);
    import riscv_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    fetch_state_e state_q, state_d;
    logic         fault_q, fault_d;
    logic         load_err_q, load_err_d;

    logic            fetch_ok;
    logic            accept;
    logic            rd_en;
    logic            load_ok;
    logic            wr_en;
    logic [XLEN-1:0] rd_data;
    logic [1:0]      unused_load_lsbs;

    // Upper address bits must be zero: wrap-around aliasing is a fault, not a hit.
    assign fetch_ok  = (inst_address[1:0] == 2'b00) && (inst_address[31:AW+2] == '0);
    assign load_ok   = (load_addr[31:AW+2] == '0);
    assign unused_load_lsbs = load_addr[1:0];

    assign req_ready = (state_q == EMPTY) | resp_ready;
    assign accept    = req_valid & req_ready;
    assign rd_en     = accept & fetch_ok;
    assign wr_en     = load_en & load_ok;

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        load_err_d = load_en & ~load_ok;
        if (accept) begin
            state_d = FULL;
            fault_d = ~fetch_ok;
        end else if ((state_q == FULL) && resp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            fault_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fault_q    <= fault_d;
            load_err_q <= load_err_d;
        end
    end

    // The RAM read register only advances on a non-faulting accept, so it doubles
    // as the backpressure hold register; faults substitute the NOP at the output.
    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_addr (inst_address[AW+1:2]),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (load_addr[AW+1:2]),
        .wr_data (load_data)
    );

    assign resp_valid  = (state_q == FULL);
    assign fetch_fault = fault_q;
    assign inst_code   = fault_q ? NOP_CODE : rd_data;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed self-checking bench for inst_fetch_responder with hand-computed expectations.
module tb_inst_fetch_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] inst_address = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] inst_code;
    logic        fetch_fault;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    inst_fetch_responder #(.DEPTH_WORDS(DEPTH), .NOP_CODE(NOP)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .inst_address (inst_address),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .inst_code    (inst_code),
        .fetch_fault  (fetch_fault),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_err     (load_err)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (resp_valid !== 1'b0 || inst_code !== 32'h0 || fetch_fault !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: valid=%b code=%h fault=%b lerr=%b, want 0/0/0/0",
                     resp_valid, inst_code, fetch_fault, load_err);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_words [4];
        exp_words = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i * 4);
            load_data = exp_words[i];
            tick();
        end
        load_en    = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_address = 32'(i * 4);
            tick();
            checks++;
            if (resp_valid !== 1'b1 || inst_code !== exp_words[i] || fetch_fault !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_word%0d: valid=%b code=%h fault=%b, want 1/%h/0",
                         i, resp_valid, inst_code, fetch_fault, exp_words[i]);
            end
        end
        req_valid = 1'b0;
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_faults();
        logic [31:0] bad_addrs [2];
        bad_addrs = '{32'h00000006, 32'hFFFFFFFC};
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inst_address = bad_addrs[i];
            tick();
            checks++;
            if (resp_valid !== 1'b1 || inst_code !== 32'h00000013 || fetch_fault !== 1'b1) begin
                errors++;
                $display("[TB] FAIL fault_%h: valid=%b code=%h fault=%b, want 1/00000013/1",
                         bad_addrs[i], resp_valid, inst_code, fetch_fault);
            end
        end
        inst_address = 32'h0;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || inst_code !== 32'h11 || fetch_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fault_recover: valid=%b code=%h fault=%b, want 1/00000011/0",
                     resp_valid, inst_code, fetch_fault);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        inst_address = 32'h4;
        tick();
        inst_address = 32'h8;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || inst_code !== 32'h22 || fetch_fault !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: valid=%b code=%h fault=%b ready=%b, want 1/00000022/0/0",
                         i, resp_valid, inst_code, fetch_fault, req_ready);
            end
            load_en   = (i == 1);
            load_addr = 32'h4;
            load_data = 32'h55;
            tick();
        end
        load_en = 1'b0;
        checks++;
        if (inst_code !== 32'h22) begin
            errors++;
            $display("[TB] FAIL hold_after_load: code=%h want 00000022", inst_code);
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_ready: got %b want 1", req_ready);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || inst_code !== 32'h33) begin
            errors++;
            $display("[TB] FAIL release_next: valid=%b code=%h, want 1/00000033", resp_valid, inst_code);
        end
        inst_address = 32'h4;
        tick();
        checks++;
        if (inst_code !== 32'h55) begin
            errors++;
            $display("[TB] FAIL reload_word1: code=%h want 00000055", inst_code);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        inst_address = 32'h8;
        load_en      = 1'b1;
        load_addr    = 32'h8;
        load_data    = 32'hAA;
        tick();
        load_en = 1'b0;
        checks++;
        if (inst_code !== 32'h33) begin
            errors++;
            $display("[TB] FAIL collision_old: code=%h want 00000033", inst_code);
        end
        tick();
        checks++;
        if (inst_code !== 32'hAA) begin
            errors++;
            $display("[TB] FAIL collision_new: code=%h want 000000aa", inst_code);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_err();
        load_en   = 1'b1;
        load_addr = 32'(4 * DEPTH);
        load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        checks++;
        if (load_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_err_pulse: got %b want 1", load_err);
        end
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        inst_address = 32'h0;
        tick();
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_err_clear: got %b want 0", load_err);
        end
        checks++;
        if (inst_code !== 32'h11 || fetch_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_err_readback: code=%h fault=%b, want 00000011/0", inst_code, fetch_fault);
        end
        inst_address = 32'(4 * DEPTH);
        tick();
        checks++;
        if (fetch_fault !== 1'b1 || inst_code !== NOP) begin
            errors++;
            $display("[TB] FAIL fetch_oor: code=%h fault=%b, want 00000013/1", inst_code, fetch_fault);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        inst_address = 32'hC;
        tick();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || inst_code !== 32'h44) begin
            errors++;
            $display("[TB] FAIL pre_reset_full: valid=%b code=%h, want 1/00000044", resp_valid, inst_code);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || inst_code !== 32'h0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%b code=%h fault=%b, want 0/0/0",
                     resp_valid, inst_code, fetch_fault);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: resp_valid=%b want 0", resp_valid);
        end
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        inst_address = 32'h0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || inst_code !== 32'h11) begin
            errors++;
            $display("[TB] FAIL post_reset_fetch: valid=%b code=%h, want 1/00000011", resp_valid, inst_code);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_faults();
        test_backpressure();
        test_collision();
        test_load_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
